obstacle_lane_ctrl: RTL and testbench

Generates and moves one obstacle per road lane on the 14x15 game grid. Detects when an obstacle occupies the frog's cell and produces the collision pulse that feeds frogger_ctrl's i_Collided input. Also answers the renderer's per-cell "obstacle here?" query using the divided column/row counters.

---
 rtl/obstacle_lane_ctrl.sv | 127 ++++++++++++
 tb/tb_obstacle_lane_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_lane_ctrl.sv
// Obstacle lanes for the frog game grid.
// One obstacle per road lane moves left or right at a lane-dependent speed,
// wrapping around the grid edges. The block reports a one-cycle collision
// pulse when an obstacle and the frog come to share a cell, and answers the
// renderer's registered "obstacle in this cell?" query.
module obstacle_lane_ctrl #(
    parameter int TICK_DIV       = 2500000,
    parameter int NUM_LANES      = 5,
    parameter int FIRST_LANE_ROW = 8,
    parameter int GRID_W         = 14
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_Game_Active,
    input  logic [5:0]             i_Frogger_X,
    input  logic [5:0]             i_Frogger_Y,
    input  logic [5:0]             i_Col_Count_Div,
    input  logic [5:0]             i_Row_Count_Div,
    output logic                   o_Obstacle_Here,
    output logic                   o_Collided,
    output logic [6*NUM_LANES-1:0] o_Lane_X
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [5:0]       lane_x   [NUM_LANES];
    logic [5:0]       next_x   [NUM_LANES];
    logic [2:0]       step_cnt [NUM_LANES];
    logic             match;
    logic             query_hit;
    logic             match_hist;

    // The movement tick fires on the cycle the divider wraps; a frozen game
    // never ticks, so the divider count survives a pause.
    assign tick = i_Game_Active && (div_cnt == DIV_MAX);

    // Movement divider: counts only while the game is active.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            div_cnt <= '0;
        end else if (i_Game_Active) begin
            if (div_cnt == DIV_MAX) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // Candidate next column per lane: even lanes go right, odd lanes go left,
    // both wrapping so X stays inside the grid.
    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            next_x[k] = lane_x[k];
            if ((k % 2) == 0) begin
                next_x[k] = (lane_x[k] == 6'(GRID_W - 1)) ? 6'd0 : lane_x[k] + 6'd1;
            end else begin
                next_x[k] = (lane_x[k] == 6'd0) ? 6'(GRID_W - 1) : lane_x[k] - 6'd1;
            end
        end
    end

    // Lane k steps once every k+1 ticks; its step counter runs 0..k.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                lane_x[k]   <= 6'((3 * k) % GRID_W);
                step_cnt[k] <= '0;
            end
        end else if (tick) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (step_cnt[k] == 3'(k)) begin
                    step_cnt[k] <= '0;
                    lane_x[k]   <= next_x[k];
                end else begin
                    step_cnt[k] <= step_cnt[k] + 3'd1;
                end
            end
        end
    end

    // Frog overlap and renderer hit, both judged against registered lane X.
    always_comb begin
        match     = 1'b0;
        query_hit = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (i_Frogger_Y == 6'(FIRST_LANE_ROW + k) && i_Frogger_X == lane_x[k]) begin
                match = 1'b1;
            end
            if (i_Row_Count_Div == 6'(FIRST_LANE_ROW + k) && i_Col_Count_Div == lane_x[k]) begin
                query_hit = 1'b1;
            end
        end
    end

    // Rising-edge detect on match; pausing clears history so a match that is
    // still present at re-activation produces a fresh pulse.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            match_hist <= 1'b0;
            o_Collided <= 1'b0;
        end else if (i_Game_Active) begin
            match_hist <= match;
            o_Collided <= match & ~match_hist;
        end else begin
            match_hist <= 1'b0;
            o_Collided <= 1'b0;
        end
    end

    // Render query answer, registered and independent of game state.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_Obstacle_Here <= 1'b0;
        end else begin
            o_Obstacle_Here <= query_hit;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane_out
        assign o_Lane_X[6*g +: 6] = lane_x[g];
    end

endmodule

// File: tb/tb_obstacle_lane_ctrl.sv
// Bench for obstacle_lane_ctrl with TICK_DIV=4.
// A reference model derives lane positions from the number of elapsed ticks
// and tracks collision history; its per-cycle predictions go through an
// expected queue and are compared at the falling edge. Directed checks with
// fixed constants cover the specific corner cases.
module tb_obstacle_lane_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int NUM_LANES = 5;
    localparam int FIRST_ROW = 8;
    localparam int GRID_W    = 14;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        rst;
    logic        game_active;
    logic [5:0]  frog_x;
    logic [5:0]  frog_y;
    logic [5:0]  col;
    logic [5:0]  row;
    logic        obstacle_here;
    logic        collided;
    logic [29:0] lane_x;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obstacle_lane_ctrl #(
        .TICK_DIV       (TICK_DIV),
        .NUM_LANES      (NUM_LANES),
        .FIRST_LANE_ROW (FIRST_ROW),
        .GRID_W         (GRID_W)
    ) dut (
        .i_Clk           (clk),
        .i_Rst           (rst),
        .i_Game_Active   (game_active),
        .i_Frogger_X     (frog_x),
        .i_Frogger_Y     (frog_y),
        .i_Col_Count_Div (col),
        .i_Row_Count_Div (row),
        .o_Obstacle_Here (obstacle_here),
        .o_Collided      (collided),
        .o_Lane_X        (lane_x)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    // expected word = {lanes[29:0], collided, obstacle_here}
    logic [31:0] exp_q[$];

    // model state
    int   m_ticks;
    int   m_div;
    logic m_hist;

    typedef struct {
        logic [5:0] col;
        logic [5:0] row;
        logic [5:0] fx;
        logic [5:0] fy;
        logic       exp_here;
        logic       exp_coll;
    } qvec_t;

    qvec_t qtab[10];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int lane_pos(input int k, input int t);
        int x0;
        int mv;
        x0 = (3 * k) % GRID_W;
        mv = (t / (k + 1)) % GRID_W;
        if ((k % 2) == 0) return (x0 + mv) % GRID_W;
        return (x0 - mv + GRID_W) % GRID_W;
    endfunction

    function automatic logic [29:0] model_lanes(input int t);
        logic [29:0] v;
        v = '0;
        for (int k = 0; k < NUM_LANES; k++) v[6*k +: 6] = 6'(lane_pos(k, t));
        return v;
    endfunction

    function automatic logic [29:0] pack5(input int a0, input int a1, input int a2,
                                          input int a3, input int a4);
        return {6'(a4), 6'(a3), 6'(a2), 6'(a1), 6'(a0)};
    endfunction

    // Predict the outputs after the coming rising edge from current inputs.
    task automatic model_step();
        logic mt;
        logic hit;
        logic coll_n;
        mt  = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (int'(frog_y) == FIRST_ROW + k && int'(frog_x) == lane_pos(k, m_ticks)) mt = 1'b1;
            if (int'(row) == FIRST_ROW + k && int'(col) == lane_pos(k, m_ticks)) hit = 1'b1;
        end
        if (game_active) begin
            coll_n = mt & ~m_hist;
            m_hist = mt;
            if (m_div == TICK_DIV - 1) begin
                m_div = 0;
                m_ticks++;
            end else begin
                m_div++;
            end
        end else begin
            coll_n = 1'b0;
            m_hist = 1'b0;
        end
        exp_q.push_back({model_lanes(m_ticks), coll_n, hit});
    endtask

    task automatic model_reset();
        m_ticks = 0;
        m_div   = 0;
        m_hist  = 1'b0;
    endtask

    task automatic compare_pop();
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_empty: got 0 entries, expected 1");
            return;
        end
        e = exp_q.pop_front();
        check("sb_lanes", int'(lane_x), int'(e[31:2]));
        check("sb_collided", int'(collided), int'(e[1]));
        check("sb_here", int'(obstacle_here), int'(e[0]));
    endtask

    // ---------------- driver ----------------
    // Inputs are stable at the falling edge; predict, clock, then compare.
    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_pop();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- test ----------------
    initial begin
        int pulses;
        int e;
        logic [29:0] frozen;

        qtab[0] = '{col: 6'd6,  row: 6'd10, fx: 6'd0,  fy: 6'd0,  exp_here: 1'b1, exp_coll: 1'b0};
        qtab[1] = '{col: 6'd6,  row: 6'd7,  fx: 6'd0,  fy: 6'd0,  exp_here: 1'b0, exp_coll: 1'b0};
        qtab[2] = '{col: 6'd0,  row: 6'd8,  fx: 6'd0,  fy: 6'd8,  exp_here: 1'b1, exp_coll: 1'b0};
        qtab[3] = '{col: 6'd3,  row: 6'd9,  fx: 6'd3,  fy: 6'd9,  exp_here: 1'b1, exp_coll: 1'b0};
        qtab[4] = '{col: 6'd9,  row: 6'd11, fx: 6'd0,  fy: 6'd0,  exp_here: 1'b1, exp_coll: 1'b0};
        qtab[5] = '{col: 6'd12, row: 6'd12, fx: 6'd12, fy: 6'd12, exp_here: 1'b1, exp_coll: 1'b0};
        qtab[6] = '{col: 6'd12, row: 6'd13, fx: 6'd0,  fy: 6'd0,  exp_here: 1'b0, exp_coll: 1'b0};
        qtab[7] = '{col: 6'd8,  row: 6'd9,  fx: 6'd0,  fy: 6'd0,  exp_here: 1'b0, exp_coll: 1'b0};
        qtab[8] = '{col: 6'd13, row: 6'd8,  fx: 6'd0,  fy: 6'd0,  exp_here: 1'b0, exp_coll: 1'b0};
        qtab[9] = '{col: 6'd3,  row: 6'd8,  fx: 6'd0,  fy: 6'd0,  exp_here: 1'b0, exp_coll: 1'b0};

        rst = 1'b1;
        game_active = 1'b0;
        frog_x = '0;
        frog_y = '0;
        col = '0;
        row = '0;
        repeat (3) @(negedge clk);

        check("reset_lanes", int'(lane_x), int'(pack5(0, 3, 6, 9, 12)));
        check("reset_collided", int'(collided), 0);
        check("reset_here", int'(obstacle_here), 0);

        rst = 1'b0;
        model_reset();

        // Render query table with the game frozen at reset positions.
        for (int i = 0; i < 10; i++) begin
            col    = qtab[i].col;
            row    = qtab[i].row;
            frog_x = qtab[i].fx;
            frog_y = qtab[i].fy;
            cyc();
            check("query_tab_here", int'(obstacle_here), int'(qtab[i].exp_here));
            check("query_tab_coll", int'(collided), int'(qtab[i].exp_coll));
        end
        col = '0;
        row = '0;

        // Active run: movement, wrap and collision edges.
        game_active = 1'b1;
        frog_x = 6'd5;
        frog_y = 6'd8;
        pulses = 0;
        for (int n = 1; n <= 58; n++) begin
            if (n == 42) begin frog_x = 6'd7; frog_y = 6'd11; end
            if (n == 44) frog_y = 6'd10;
            if (n == 45) frog_y = 6'd11;
            if (n == 47) begin frog_x = 6'd0; frog_y = 6'd0; end
            cyc();
            if (n == 4) begin
                check("lane0_first_step", int'(lane_x[5:0]), 1);
                check("lane1_still", int'(lane_x[11:6]), 3);
            end
            if (n == 8) begin
                check("lane0_second_step", int'(lane_x[5:0]), 2);
                check("lane1_first_step", int'(lane_x[11:6]), 2);
            end
            if (n == 20) begin
                check("lane0_onto_frog", int'(lane_x[5:0]), 5);
                check("coll_not_yet", int'(collided), 0);
            end
            if (n == 21) check("coll_obstacle_step", int'(collided), 1);
            if (n >= 22 && n <= 41 && collided) pulses++;
            if (n == 41) check("no_repeat_pulse", pulses, 0);
            if (n == 28) check("lane1_at_zero", int'(lane_x[11:6]), 0);
            if (n == 32) check("lane1_wrap", int'(lane_x[11:6]), 13);
            if (n == 42) check("coll_frog_step", int'(collided), 1);
            if (n == 43) check("coll_single", int'(collided), 0);
            if (n == 44) check("coll_off_row", int'(collided), 0);
            if (n == 45) check("coll_reenter", int'(collided), 1);
            if (n == 46) check("coll_reenter_single", int'(collided), 0);
            if (n == 52) check("lane0_at_13", int'(lane_x[5:0]), 13);
            if (n == 56) check("lane0_wrap", int'(lane_x[5:0]), 0);
        end

        // Freeze with the frog on lane 2's obstacle; divider held at 2.
        game_active = 1'b0;
        frog_x = 6'd10;
        frog_y = 6'd10;
        frozen = pack5(0, 10, 10, 6, 0);
        pulses = 0;
        for (int n = 0; n < 50; n++) begin
            cyc();
            if (collided) pulses++;
        end
        check("freeze_lanes", int'(lane_x), int'(frozen));
        check("freeze_no_pulse", pulses, 0);

        game_active = 1'b1;
        cyc();
        check("reactivate_pulse", int'(collided), 1);
        check("reactivate_lane0_held", int'(lane_x[5:0]), 0);
        cyc();
        check("reactivate_single", int'(collided), 0);
        check("resume_lane0", int'(lane_x[5:0]), 1);

        // Query lane 2 at X=11, then reset asynchronously mid-cycle.
        col = 6'd11;
        row = 6'd10;
        cyc();
        check("query_moving_lane", int'(obstacle_here), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_lanes", int'(lane_x), int'(pack5(0, 3, 6, 9, 12)));
        check("async_collided", int'(collided), 0);
        check("async_here", int'(obstacle_here), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int n = 1; n <= 4; n++) begin
            cyc();
            e = (n == 4) ? 1 : 0;
            check("post_reset_lane0", int'(lane_x[5:0]), e);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
